esc_array: RTL and testbench
============================

Name: esc_array

Overview:
N-channel ESC PWM generator; parametrised successor to the fixed 4-motor ESC interface driven by flight control. Captures packed motor speeds on a write strobe and applies them glitch-free at PWM frame boundaries. Adds per-frame slew limiting, a frame-based command watchdog and an explicit arm/disarm/trip state machine. Sits between flght_cntrl (speeds, vld as wrt) and the motor pins; cmd_cfg supplies motors_off.

Parameters:
NUM_MOTORS, 4, channel count (1..16)
SPD_W, 11, speed width per channel
PERIOD, 1000000, PWM frame length in clk cycles (20 ms at 50 MHz)
MIN_PULSE, 50000, pulse width for speed 0 (1 ms)
SPD_MULT, 24, cycles added per speed LSB
SLEW_MAX, 64, max speed change per channel per frame
WDOG_FRAMES, 4, frames without wrt before trip

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
spd_in  in  NUM_MOTORS*SPD_W  packed speeds, channel 0 in LSBs
wrt  in  1  one-cycle strobe: capture spd_in
motors_off  in  1  force all outputs low, disarm
pwm  out  NUM_MOTORS  motor PWM, bit i = channel i
armed  out  1  high in ARMED state
wdog_trip  out  1  high in TRIP state
frame_strt  out  1  one-cycle pulse when frame counter = 0

Behaviour:
- Reset: pwm=0, armed=0, wdog_trip=0, frame_strt=0, frame counter=0, pending/target/active speeds=0, wdog count=0, state OFF.
- Frame counter: counts 0..PERIOD-1, wraps to 0; frame_strt registered, high the cycle after counter = 0.
- wrt: spd_in captured into pending next edge. At each frame boundary (counter = PERIOD-1), pending -> target. A wrt in the same cycle as the boundary updates pending only; it reaches target at the following boundary (latency one to two frames).
- Active speed updates at the boundary toward target: |target - active| <= SLEW_MAX gives active = target; otherwise active moves by +/-SLEW_MAX. Unsigned arithmetic, no wrap.
- Pulse width = MIN_PULSE + active*SPD_MULT, in clog2(PERIOD) bits. Elaboration error if MIN_PULSE + (2^SPD_W-1)*SPD_MULT >= PERIOD.
- pwm[i] registered: high while counter < pulse width, else low; only in ARMED or TRIP.
- States:
  - OFF: pwm=0; active and target forced 0. OFF->ARMED on wrt with motors_off low.
  - ARMED: normal output. ARMED->TRIP when wdog count reaches WDOG_FRAMES.
  - TRIP: targets forced 0, so channels slew down to idle (MIN_PULSE pulses, not 0). TRIP->ARMED on wrt.
  - motors_off high: any state -> OFF on the next edge, pwm low that edge, mid-pulse included.
- Watchdog: counts frame boundaries in ARMED and clears on wrt. If wrt and expiry coincide, wrt wins and the state stays ARMED.
- rst mid-frame: everything returns to reset values next edge; counter restarts at 0.

Optional Feature:
ESC_SLEW_LIMIT_EN: defined gives slew limiting as above. Undefined gives active = target at every boundary; SLEW_MAX is ignored and TRIP drops to idle in one frame.

Decomposition:
- esc_pkg: state enum (OFF, ARMED, TRIP), clog2-derived counter width localparam, pulse-width helper function.
- Sub-module esc_chan, generated NUM_MOTORS times: holds pending/target/active, slew step and pulse compare. The top keeps the frame counter, watchdog and FSM.

Test Plan:
- Reset, then wrt spd=0 with motors_off=0 -> armed=1 next cycle; each pwm high 50000 cycles per 1000000-cycle frame.
- Slew enabled, wrt all channels 1000 -> active steps 0,64,128,... reaching 1000 after 16 frames; final pulse = 50000 + 1000*24 = 74000 cycles.
- Steady at 1000, no wrt for 4 frames -> wdog_trip=1 and armed=0; pulses ramp down to 50000; a further wrt -> armed=1, wdog_trip=0.
- motors_off asserted at counter = 30000 (mid-pulse) -> all pwm low next cycle, armed=0; pwm stays low until motors_off low and a wrt arrives.
- wrt spd=500 exactly at counter = PERIOD-1 -> target unchanged that boundary; takes 500 at the next boundary.
- NUM_MOTORS=6 build: distinct speeds 0,100,...,500 per channel -> each pulse width = 50000 + 24*spd with slew disabled, after 1-2 frames.

Source files
------------

// File: rtl/esc_pkg.sv
// esc_pkg: shared types and helpers for the ESC PWM array.
//   esc_state_e  - arm/disarm/trip state encoding
//   CNT_W_DEF    - frame counter width for the default 1,000,000-cycle frame
//   cnt_width()  - clog2-based width with a floor of one bit
//   pulse_width()- MIN_PULSE + speed * SPD_MULT
package esc_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRIP  = 2'd2
  } esc_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned PERIOD_DEF = 1000000;
  localparam int unsigned CNT_W_DEF  = cnt_width(PERIOD_DEF);

  function automatic int unsigned pulse_width(input int unsigned spd,
                                              input int unsigned min_pulse,
                                              input int unsigned mult);
    return min_pulse + spd * mult;
  endfunction

endpackage

// File: rtl/esc_chan.sv
// esc_chan: one ESC channel. Holds pending/target/active speed, steps the
// active speed at frame boundaries and compares the frame counter against
// the resulting pulse width.
// Build option: ESC_SLEW_LIMIT_EN defined limits the per-frame step to
// SLEW_MAX; undefined jumps straight to the target.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   spd_in          speed captured on wrt
//   wrt             capture strobe
//   boundary        counter is on its last cycle of the frame
//   tgt_zero        next state is not ARMED: target held at 0
//   act_zero        next state is OFF: active speed held at 0
//   run             next state drives pulses (ARMED or TRIP)
//   cnt             frame counter
//   pwm             registered pulse output
module esc_chan
  import esc_pkg::*;
#(
  parameter int unsigned SPD_W     = 11,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned MIN_PULSE = 50000,
  parameter int unsigned SPD_MULT  = 24,
  parameter int unsigned SLEW_MAX  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SPD_W-1:0] spd_in,
  input  logic             wrt,
  input  logic             boundary,
  input  logic             tgt_zero,
  input  logic             act_zero,
  input  logic             run,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm
);

`ifdef ESC_SLEW_LIMIT_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  logic [SPD_W-1:0] pend_q, pend_d;
  logic [SPD_W-1:0] tgt_q, tgt_d;
  logic [SPD_W-1:0] act_q, act_d;
  logic [SPD_W-1:0] tgt_nxt, act_step;
  logic [CNT_W-1:0] pulse_w;
  logic             pwm_q, pwm_d;

  always_comb begin
    pend_d = wrt ? spd_in : pend_q;

    // active steps toward the target being loaded at this same boundary,
    // so a mid-frame write shows up one frame later
    tgt_nxt = boundary ? pend_q : tgt_q;
    if (tgt_zero) tgt_nxt = '0;
    tgt_d = tgt_nxt;

    // compared in 32 bits so the difference never wraps
    act_step = tgt_nxt;
    if (SLEW_EN) begin
      if (32'(tgt_nxt) > 32'(act_q) + SLEW_MAX)
        act_step = act_q + SPD_W'(SLEW_MAX);
      else if (32'(act_q) > 32'(tgt_nxt) + SLEW_MAX)
        act_step = act_q - SPD_W'(SLEW_MAX);
    end

    act_d = boundary ? act_step : act_q;
    if (act_zero) act_d = '0;

    pulse_w = CNT_W'(pulse_width(32'(act_q), MIN_PULSE, SPD_MULT));
    pwm_d   = run && (cnt < pulse_w);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      tgt_q  <= '0;
      act_q  <= '0;
      pwm_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      tgt_q  <= tgt_d;
      act_q  <= act_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/esc_array.sv
// esc_array: N-channel ESC PWM generator with frame counter, command
// watchdog and arm/disarm/trip state machine. Speeds written on wrt are
// applied only at frame boundaries so pulses never glitch mid-frame.
// Build option: ESC_SLEW_LIMIT_EN enables per-frame slew limiting in the
// channels (see esc_chan).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   spd_in       packed speeds, channel 0 in the LSBs
//   wrt          one-cycle strobe capturing spd_in
//   motors_off   force outputs low and disarm
//   pwm          per-channel PWM
//   armed        high in ARMED
//   wdog_trip    high in TRIP
//   frame_strt   one-cycle pulse the cycle after the counter is 0
//
// state | meaning
// OFF   | outputs low, speeds held at 0, waiting for a write
// ARMED | normal output, watchdog counting frames without a write
// TRIP  | watchdog expired, channels fall back to idle pulses
module esc_array
  import esc_pkg::*;
#(
  parameter int unsigned NUM_MOTORS  = 4,
  parameter int unsigned SPD_W       = 11,
  parameter int unsigned PERIOD      = 1000000,
  parameter int unsigned MIN_PULSE   = 50000,
  parameter int unsigned SPD_MULT    = 24,
  parameter int unsigned SLEW_MAX    = 64,
  parameter int unsigned WDOG_FRAMES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_MOTORS*SPD_W-1:0] spd_in,
  input  logic                        wrt,
  input  logic                        motors_off,
  output logic [NUM_MOTORS-1:0]       pwm,
  output logic                        armed,
  output logic                        wdog_trip,
  output logic                        frame_strt
);

  localparam int unsigned CNT_W = cnt_width(PERIOD);
  localparam int unsigned WD_W  = cnt_width(WDOG_FRAMES + 1);

  if (longint'(MIN_PULSE) + ((longint'(1) << SPD_W) - 1) * longint'(SPD_MULT)
      >= longint'(PERIOD)) begin : g_bad_pulse
    $error("esc_array: maximum pulse width does not fit inside PERIOD");
  end
  if (NUM_MOTORS < 1 || NUM_MOTORS > 16 || WDOG_FRAMES < 1) begin : g_bad_cfg
    $error("esc_array: NUM_MOTORS must be 1..16 and WDOG_FRAMES at least 1");
  end

  esc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             frame_strt_q, frame_strt_d;
  logic             boundary, wdog_exp;
  logic             tgt_zero, act_zero, run;

  always_comb begin
    boundary     = (cnt_q == CNT_W'(PERIOD - 1));
    cnt_d        = boundary ? '0 : cnt_q + 1'b1;
    frame_strt_d = (cnt_q == '0);

    // a write on the expiring boundary keeps the channel armed
    wdog_exp = boundary && !wrt && (32'(wdog_q) + 1 >= WDOG_FRAMES);

    state_d = state_q;
    unique case (state_q)
      ST_OFF:   if (wrt)      state_d = ST_ARMED;
      ST_ARMED: if (wdog_exp) state_d = ST_TRIP;
      ST_TRIP:  if (wrt)      state_d = ST_ARMED;
      default:                state_d = ST_OFF;
    endcase
    if (motors_off) state_d = ST_OFF;

    wdog_d = wdog_q;
    if (state_d != ST_ARMED || wrt) wdog_d = '0;
    else if (boundary)              wdog_d = wdog_q + 1'b1;

    // next-state based so motors_off clears pwm on the very next edge
    tgt_zero = (state_d != ST_ARMED);
    act_zero = (state_d == ST_OFF);
    run      = (state_d != ST_OFF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      wdog_q       <= '0;
      frame_strt_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wdog_q       <= wdog_d;
      frame_strt_q <= frame_strt_d;
    end
  end

  for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_chan
    esc_chan #(
      .SPD_W    (SPD_W),
      .CNT_W    (CNT_W),
      .MIN_PULSE(MIN_PULSE),
      .SPD_MULT (SPD_MULT),
      .SLEW_MAX (SLEW_MAX)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .spd_in  (spd_in[i*SPD_W +: SPD_W]),
      .wrt     (wrt),
      .boundary(boundary),
      .tgt_zero(tgt_zero),
      .act_zero(act_zero),
      .run     (run),
      .cnt     (cnt_q),
      .pwm     (pwm[i])
    );
  end

  assign armed      = (state_q == ST_ARMED);
  assign wdog_trip  = (state_q == ST_TRIP);
  assign frame_strt = frame_strt_q;

endmodule

// File: tb/tb_esc_array.sv
module tb_esc_array;

  localparam int NM   = 6;
  localparam int SW   = 4;
  localparam int PER  = 200;
  localparam int MINP = 20;
  localparam int MULT = 8;
  localparam int SLEW = 3;
  localparam int WDF  = 4;

  localparam int M_OFF   = 0;
  localparam int M_ARMED = 1;
  localparam int M_TRIP  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wrt = 1'b0;
  logic             motors_off = 1'b0;
  logic [NM*SW-1:0] spd_in = '0;
  logic [NM-1:0]    pwm;
  logic             armed, wdog_trip, frame_strt;

  esc_array #(
    .NUM_MOTORS (NM),
    .SPD_W      (SW),
    .PERIOD     (PER),
    .MIN_PULSE  (MINP),
    .SPD_MULT   (MULT),
    .SLEW_MAX   (SLEW),
    .WDOG_FRAMES(WDF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .spd_in    (spd_in),
    .wrt       (wrt),
    .motors_off(motors_off),
    .pwm       (pwm),
    .armed     (armed),
    .wdog_trip (wdog_trip),
    .frame_strt(frame_strt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input longint obs, input longint expv);
    total++;
    if (obs != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // reference model: speeds per channel and the controller mode
  int m_pend[NM];
  int m_tgt[NM];
  int m_act[NM];
  int m_st;
  int m_wd;

  function automatic void model_reset();
    for (int c = 0; c < NM; c++) begin
      m_pend[c] = 0;
      m_tgt[c]  = 0;
      m_act[c]  = 0;
    end
    m_st = M_OFF;
    m_wd = 0;
  endfunction

  function automatic int slew_to(input int a, input int t);
`ifdef ESC_SLEW_LIMIT_EN
    if (t > a + SLEW) return a + SLEW;
    if (a > t + SLEW) return a - SLEW;
`endif
    return t;
  endfunction

  // One frame, entered at a negedge with the DUT counter at 0. Event offsets
  // of -1 mean "not in this frame".
  task automatic run_frame(input int wrt_at, input logic [NM*SW-1:0] spd,
                           input int moff_on, input int moff_off, input int rst_at);
    int hi[NM];
    int exp_hi[NM];
    int fs_cnt;
    int fs_pos;
    fs_cnt = 0;
    fs_pos = -1;
    for (int c = 0; c < NM; c++) begin
      hi[c]     = 0;
      exp_hi[c] = 0;
    end
    for (int i = 0; i < PER; i++) begin
      bit w;
      bit bnd;
      w   = (i == wrt_at);
      bnd = (i == PER - 1);
      wrt    = w;
      spd_in = spd;
      if (i == moff_on)  motors_off = 1'b1;
      if (i == moff_off) motors_off = 1'b0;
      if (i == rst_at) begin
        rst = 1'b1;
        wrt = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_pwm", pwm, 0);
        check("midrst_armed", armed, 0);
        check("midrst_trip", wdog_trip, 0);
        check("midrst_fs", frame_strt, 0);
        model_reset();
        rst = 1'b0;
        return;
      end

      if (motors_off) m_st = M_OFF;
      else if (w) begin
        m_st = M_ARMED;
        m_wd = 0;
      end else if (bnd && m_st == M_ARMED) begin
        m_wd++;
        if (m_wd >= WDF) m_st = M_TRIP;
      end
      if (m_st != M_ARMED) m_wd = 0;

      for (int c = 0; c < NM; c++)
        if (m_st != M_OFF && i < MINP + m_act[c] * MULT) exp_hi[c]++;

      for (int c = 0; c < NM; c++) begin
        if (bnd) begin
          m_tgt[c] = (m_st == M_ARMED) ? m_pend[c] : 0;
          m_act[c] = slew_to(m_act[c], m_tgt[c]);
        end
        if (m_st != M_ARMED) m_tgt[c] = 0;
        if (m_st == M_OFF)   m_act[c] = 0;
        if (w) m_pend[c] = int'(spd[c*SW +: SW]);
      end

      @(posedge clk);
      @(negedge clk);
      for (int c = 0; c < NM; c++) hi[c] += int'(pwm[c]);
      if (frame_strt) begin
        fs_cnt++;
        if (fs_pos < 0) fs_pos = i;
      end
      if (i == moff_on) begin
        check("moff_pwm", pwm, 0);
        check("moff_armed", armed, 0);
      end
    end
    wrt = 1'b0;
    for (int c = 0; c < NM; c++) check($sformatf("pulse_ch%0d", c), hi[c], exp_hi[c]);
    check("fs_count", fs_cnt, 1);
    check("fs_pos", fs_pos, 0);
    check("armed", armed, (m_st == M_ARMED) ? 1 : 0);
    check("wdog_trip", wdog_trip, (m_st == M_TRIP) ? 1 : 0);
  endtask

  initial begin
    logic [NM*SW-1:0] s;
    int w;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pwm", pwm, 0);
    check("rst_armed", armed, 0);
    check("rst_trip", wdog_trip, 0);
    check("rst_fs", frame_strt, 0);
    rst = 1'b0;

    // arm at speed 0: idle pulses
    s = '0;
    run_frame(0, s, -1, -1, -1);

    // full speed on all channels and keep writing while it settles
    s = '1;
    run_frame(5, s, -1, -1, -1);
    repeat (6) run_frame(int'($urandom_range(0, PER - 2)), s, -1, -1, -1);

    // random speeds, write offsets including the boundary and skipped writes
    repeat (10) begin
      for (int c = 0; c < NM; c++) s[c*SW +: SW] = SW'($urandom);
      case ($urandom_range(0, 3))
        0:       w = -1;
        1:       w = PER - 1;
        default: w = int'($urandom_range(0, PER - 1));
      endcase
      run_frame(w, s, -1, -1, -1);
    end

    // write coinciding with watchdog expiry keeps the array armed
    s = '1;
    run_frame(3, s, -1, -1, -1);
    repeat (2) run_frame(-1, s, -1, -1, -1);
    run_frame(PER - 1, s, -1, -1, -1);
    check("wrt_beats_wdog", armed, 1);

    // starve the watchdog: trip and ramp down to idle
    repeat (9) run_frame(-1, s, -1, -1, -1);
    check("trip_seen", wdog_trip, 1);

    // rearm and climb again
    run_frame(40, s, -1, -1, -1);
    check("rearm", armed, 1);
    repeat (4) run_frame(int'($urandom_range(0, PER - 1)), s, -1, -1, -1);

    // motors_off mid-pulse, writes ignored while it is held, release without write
    run_frame(-1, s, 30, -1, -1);
    run_frame(10, s, -1, -1, -1);
    run_frame(-1, s, -1, 0, -1);
    check("off_stays", armed, 0);
    run_frame(7, s, -1, -1, -1);

    // write on the boundary cycle lands one frame later
    for (int c = 0; c < NM; c++) s[c*SW +: SW] = SW'(5);
    run_frame(PER - 1, s, -1, -1, -1);
    repeat (3) run_frame(50, s, -1, -1, -1);

    // distinct per-channel speeds
    for (int c = 0; c < NM; c++) s[c*SW +: SW] = SW'(2 * c + 1);
    repeat (4) run_frame(int'($urandom_range(0, PER - 1)), s, -1, -1, -1);

    // reset mid-frame then bring it back up
    run_frame(-1, s, -1, -1, 77);
    run_frame(0, s, -1, -1, -1);
    repeat (3) run_frame(int'($urandom_range(0, PER - 1)), s, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
